ntt_dit_scheduler: RTL

//  Sequences one radix-2 DIT NTT (or pointwise-multiply pass) through a single dit_butterfly.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/ntt_sched_delay.sv | 27 ++
 rtl/ntt_dit_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared FSM state type and size/latency derivations for the NTT scheduler
`ifndef MODRED_DELAY
`define MODRED_DELAY 2
`endif
`ifndef INTMUL_DELAY
`define INTMUL_DELAY 1
`endif
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  localparam int BF_LAT_DEF = `MODRED_DELAY + `INTMUL_DELAY + 1;
  function automatic int ntt_dly(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction
  function automatic int ntt_n(input int logn);
    return 1 << logn;
  endfunction
endpackage

// File: rtl/ntt_sched_delay.sv
// ntt_sched_delay: valid+data shift register of fixed depth aligning write-back with butterfly output
module ntt_sched_delay #(
  parameter int DEPTH = 5,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0] d [DEPTH];
  // shift valid and data one stage per cycle; reset empties the line so no stale write survives
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v <= '0;
      for (int n = 0; n < DEPTH; n++) d[n] <= '0;
    end else begin
      v <= DEPTH'({v, in_valid});
      d[0] <= in_data;
      for (int n = 1; n < DEPTH; n++) d[n] <= d[n-1];
    end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/ntt_dit_scheduler.sv
// ntt_dit_scheduler: sequences a radix-2 DIT NTT through one butterfly; NTT_PWMUL_EN adds a pointwise-multiply pass
module ntt_dit_scheduler import ntt_pkg::*; #(
  parameter int LOGN = 10,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            pw_mode,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            bf_mode,
  output logic            wr_en_a,
  output logic            wr_en_b,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);
  localparam int N = ntt_n(LOGN);
  localparam int DLY = ntt_dly(RD_LAT, BF_LAT);
  localparam int SW = LOGN > 1 ? $clog2(LOGN) : 1;
  localparam int DW = $clog2(DLY + 1);
  state_t state;
  logic [SW-1:0] s, ns;
  logic [LOGN-1:0] i, ni, na, nb, nt;
  logic [DW-1:0] dcnt;
  logic pw, npw, pw_en, last_i, last_s, wr_v, wb_en;
  logic [RD_LAT-1:0] bf_sr;
  logic [2*LOGN:0] dl_out;
`ifdef NTT_PWMUL_EN
  assign pw_en = pw_mode;
`else
  logic unused_pw;
  assign pw_en = 1'b0;
  assign unused_pw = pw_mode;
`endif
  function automatic logic [3*LOGN-1:0] ntt_addr(input logic [SW-1:0] st, input logic [LOGN-1:0] ix);
    logic [LOGN-1:0] half, k, a;
    half = LOGN'(1) << st;
    k = ix & (half - 1'b1);
    a = (((ix >> st) << st) << 1) | k;
    return {a, a + half, k << (SW'(LOGN-1) - st)};
  endfunction
  // next issue indices and addresses: fresh stage from IDLE/DRAIN, otherwise the following butterfly
  always_comb begin
    ns = state == DRAIN ? s + 1'b1 : state == ISSUE ? s : '0;
    ni = state == ISSUE ? i + 1'b1 : '0;
    npw = state == IDLE ? pw_en : pw;
    {na, nb, nt} = npw ? {ni, ni, ni} : ntt_addr(ns, ni);
  end
  assign last_i = pw ? i == LOGN'(N - 1) : i == LOGN'(N / 2 - 1);
  assign last_s = pw || s == SW'(LOGN - 1);
  // pass sequencer: issue a stage, drain the pipeline, repeat until the last stage, then pulse done
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      i <= '0;
      dcnt <= '0;
      pw <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          busy <= 1'b1;
          pw <= npw;
          s <= ns;
          i <= ni;
          rd_en <= 1'b1;
          {rd_addr_a, rd_addr_b, tw_addr} <= {na, nb, nt};
        end
        ISSUE: if (last_i) begin
          state <= DRAIN;
          rd_en <= 1'b0;
          dcnt <= '0;
        end else begin
          i <= ni;
          {rd_addr_a, rd_addr_b, tw_addr} <= {na, nb, nt};
        end
        DRAIN: if (dcnt != DW'(DLY - 1)) dcnt <= dcnt + 1'b1;
        else if (last_s) begin
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          state <= ISSUE;
          s <= ns;
          i <= ni;
          rd_en <= 1'b1;
          {rd_addr_a, rd_addr_b, tw_addr} <= {na, nb, nt};
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // multiply mode reaches the butterfly together with the operands, RD_LAT after the read
  always_ff @(posedge clk or negedge reset)
    if (!reset) bf_sr <= '0;
    else bf_sr <= RD_LAT'({bf_sr, rd_en & pw});
  assign bf_mode = bf_sr[RD_LAT-1];
  ntt_sched_delay #(.DEPTH(DLY), .W(2 * LOGN + 1)) u_dly (
    .clk(clk),
    .reset(reset),
    .in_valid(rd_en),
    .in_data({~pw, rd_addr_a, rd_addr_b}),
    .out_valid(wr_v),
    .out_data(dl_out)
  );
  assign {wb_en, wr_addr_a, wr_addr_b} = dl_out;
  assign wr_en_a = wr_v;
  assign wr_en_b = wr_v & wb_en;
endmodule
